neopix_serializer: RTL and testbench

//  WS2812/NeoPixel line driver, downstream of the banked LED RAM in the SPI-to-NeoPixel path.

---
 rtl/neopix_serializer.sv | 159 +++++++++++++++
 tb/tb_neopix_serializer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/neopix_serializer.sv
// WS2812/NeoPixel line driver: fetches one GRB word per LED through a
// request/address handshake, serialises it MSB-first with NRZ pulse-width
// coding, then holds the line low for the latch period. Frames repeat forever.
module neopix_serializer #(
    parameter int unsigned NUM_LEDS     = 8,
    parameter int unsigned SYSTEM_CLOCK = 50000000,
    parameter int unsigned T0H_NS       = 400,
    parameter int unsigned T1H_NS       = 800,
    parameter int unsigned BIT_NS       = 1250,
    parameter int unsigned RESET_NS     = 60000,
    localparam int unsigned AW          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    output logic          reset_state,
    output logic          data_request,
    output logic          new_address,
    output logic [AW-1:0] address,
    input  logic [7:0]    red_in,
    input  logic [7:0]    green_in,
    input  logic [7:0]    blue_in,
    output logic          DO
);

    localparam int unsigned CLK_MHZ   = SYSTEM_CLOCK / 1000000;
    localparam int unsigned T0H_CYC   = CLK_MHZ * T0H_NS / 1000;
    localparam int unsigned T1H_CYC   = CLK_MHZ * T1H_NS / 1000;
    localparam int unsigned BIT_CYC   = CLK_MHZ * BIT_NS / 1000;
    localparam int unsigned RESET_CYC = CLK_MHZ * RESET_NS / 1000;
    localparam int unsigned CW        = $clog2(RESET_CYC);
    localparam int unsigned BW        = $clog2(BIT_CYC);
    localparam int unsigned WW        = 24;
    localparam int unsigned IW        = 5;

    typedef enum logic {
        ST_RESET = 1'b0,
        ST_SEND  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WW-1:0]   shift_q, shift_d;
    logic [IW-1:0]   bit_idx_q, bit_idx_d;
    logic [AW-1:0]   led_idx_q, led_idx_d;
    logic            load_c;
    logic            do_q, do_d;
    logic            reset_state_q, reset_state_d;
    logic            data_request_q, data_request_d;
    logic            new_address_q, new_address_d;
    logic [AW-1:0]   address_q, address_d;

    // State, datapath and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= ST_RESET;
            cnt_q          <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            bit_idx_q      <= IW'(23);
            led_idx_q      <= '0;
            do_q           <= 1'b0;
            reset_state_q  <= 1'b1;
            data_request_q <= 1'b0;
            new_address_q  <= 1'b0;
            address_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            bit_idx_q      <= bit_idx_d;
            led_idx_q      <= led_idx_d;
            do_q           <= do_d;
            reset_state_q  <= reset_state_d;
            data_request_q <= data_request_d;
            new_address_q  <= new_address_d;
            address_q      <= address_d;
        end
    end

    // Next state: latch countdown, bit timing, word loads at LED boundaries
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        led_idx_d = led_idx_q;
        load_c    = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (cnt_q == CW'(RESET_CYC - 1)) begin
                    state_d   = ST_SEND;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    shift_d   = {green_in, red_in, blue_in};
                    bit_idx_d = IW'(23);
                    load_c    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SEND: begin
                if (bit_cnt_q == BW'(BIT_CYC - 1)) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q != '0) begin
                        shift_d   = shift_q << 1;
                        bit_idx_d = bit_idx_q - IW'(1);
                    end else if (led_idx_q == AW'(NUM_LEDS - 1)) begin
                        state_d   = ST_RESET;
                        cnt_d     = '0;
                        shift_d   = shift_q << 1;
                        bit_idx_d = IW'(23);
                        led_idx_d = '0;
                    end else begin
                        // next LED's bit 23 follows with no gap
                        shift_d   = {green_in, red_in, blue_in};
                        bit_idx_d = IW'(23);
                        led_idx_d = led_idx_q + AW'(1);
                        load_c    = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    // Outputs computed from next-state values so they register in step with it
    always_comb begin
        do_d           = 1'b0;
        reset_state_d  = (state_d == ST_RESET);
        data_request_d = 1'b0;
        new_address_d  = load_c;
        address_d      = address_q;
        if (state_d == ST_SEND) begin
            do_d = bit_cnt_d < (shift_d[WW-1] ? BW'(T1H_CYC) : BW'(T0H_CYC));
        end
        if ((state_d == ST_RESET) && (cnt_d == CW'(RESET_CYC - 2))) begin
            data_request_d = 1'b1;
        end
        if ((state_d == ST_SEND) && (bit_idx_d == '0) &&
            (bit_cnt_d == BW'(BIT_CYC - 2)) && (led_idx_d != AW'(NUM_LEDS - 1))) begin
            data_request_d = 1'b1;
        end
        if (load_c) begin
            address_d = (led_idx_d == AW'(NUM_LEDS - 1)) ? '0 : led_idx_d + AW'(1);
        end
    end

    assign DO           = do_q;
    assign reset_state  = reset_state_q;
    assign data_request = data_request_q;
    assign new_address  = new_address_q;
    assign address      = address_q;

endmodule

// File: tb/tb_neopix_serializer.sv
// Bench for neopix_serializer: random colour data checked against a
// frame-timeline model computed from cycle offsets within the frame.
module tb_neopix_serializer;

    localparam int unsigned N       = 4;
    localparam int unsigned RST_C   = 3000;
    localparam int unsigned BIT_C   = 62;
    localparam int unsigned T0H     = 20;
    localparam int unsigned T1H     = 40;
    localparam int unsigned LED_C   = 24 * BIT_C;
    localparam int unsigned FRAME_C = RST_C + N * LED_C;

    logic       CLK = 1'b0;
    logic       RST;
    logic       reset_state, data_request, new_address, DO;
    logic [1:0] address;
    logic [7:0] red_in, green_in, blue_in;

    neopix_serializer #(.NUM_LEDS(N)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .reset_state  (reset_state),
        .data_request (data_request),
        .new_address  (new_address),
        .address      (address),
        .red_in       (red_in),
        .green_in     (green_in),
        .blue_in      (blue_in),
        .DO           (DO)
    );

    always #10 CLK = ~CLK;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // model state
    logic [23:0] wexp [N];
    int unsigned t = 0;
    int unsigned frame = 0;
    int unsigned req_cnt = 0;
    int unsigned lat = 0;
    int unsigned last_rise = 0;
    bit          have_rise = 0;
    bit          seen_req = 0;
    bit          seen_rise = 0;
    logic        prev_do = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d frame=%0d: got %0h expected %0h", tag, t, frame, got, exp);
        end
    endtask

    // One clock: check outputs against the model, measure, drive inputs, advance
    task automatic run_cycle(input bit assert_rst);
        logic        e_do, e_rs, e_req, e_na, sample;
        logic [1:0]  e_addr;
        logic [23:0] w;
        int unsigned s, k, bi, b, ki;
        e_rs   = (t < RST_C);
        e_do   = 1'b0;
        e_addr = 2'd0;
        e_na   = 1'b0;
        e_req  = 1'b0;
        sample = 1'b0;
        ki     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (t == RST_C + i * LED_C - 2) e_req = 1'b1;
            if (t == RST_C + i * LED_C - 1) begin
                sample = 1'b1;
                ki     = i;
            end
        end
        if (!e_rs) begin
            s      = t - RST_C;
            k      = s / LED_C;
            bi     = (s / BIT_C) % 24;
            b      = s % BIT_C;
            e_addr = 2'((k + 1) % N);
            e_na   = ((s % LED_C) == 0);
            e_do   = (b < (wexp[k][23 - bi] ? T1H : T0H));
        end
        check("DO", 32'(DO), 32'(e_do));
        check("reset_state", 32'(reset_state), 32'(e_rs));
        check("data_request", 32'(data_request), 32'(e_req));
        check("new_address", 32'(new_address), 32'(e_na));
        check("address", 32'(address), 32'(e_addr));

        // direct measurements of the headline timing properties
        if (data_request === 1'b1) begin
            req_cnt++;
            if (frame == 0 && !seen_req) begin
                check("first_req_cycle", t, RST_C - 2);
                seen_req = 1'b1;
            end
        end
        if (t == FRAME_C - 1) check("req_per_frame", req_cnt, N);
        if (DO === 1'b1 && prev_do !== 1'b1) begin
            if (frame == 0 && !seen_rise) begin
                check("first_rise_cycle", t, RST_C);
                seen_rise = 1'b1;
            end
            if (have_rise) check("rise_gap", t - last_rise, BIT_C);
            last_rise = t;
            have_rise = 1'b1;
        end
        prev_do = DO;
        if (reset_state === 1'b1) begin
            lat++;
            have_rise = 1'b0;
        end else if (lat > 0) begin
            check("latch_len", lat, RST_C);
            lat = 0;
        end

        // inputs: toggling noise except on the sample cycle
        if (sample) begin
            if (frame == 0 && ki == 0)                  w = 24'hA500FF;
            else if (frame == 0 && (ki == 1 || ki == 2)) w = 24'hFFFFFF;
            else                                         w = 24'($urandom);
            wexp[ki] = w;
            {green_in, red_in, blue_in} = w;
        end else begin
            red_in   = ~red_in;
            green_in = 8'($urandom);
            blue_in  = 8'($urandom);
        end
        RST = assert_rst;

        @(posedge CLK);
        #1;
        if (assert_rst || t == FRAME_C - 1) begin
            t       = 0;
            frame   = frame + 1;
            req_cnt = 0;
        end else begin
            t = t + 1;
        end
    endtask

    initial begin
        int unsigned target;
        RST      = 1'b1;
        red_in   = 8'h55;
        green_in = 8'h00;
        blue_in  = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        t   = 0;

        // two complete frames from power-on
        repeat (2 * FRAME_C) run_cycle(1'b0);

        // reset mid-bit: LED2, bit 10, b=15
        target = RST_C + 2 * LED_C + 10 * BIT_C + 15;
        while (t != target) run_cycle(1'b0);
        run_cycle(1'b1);

        // full latch and frame after the reset, plus the start of the next one
        repeat (FRAME_C + RST_C + 200) run_cycle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
